ascon_ctrl_fsm: RTL and testbench
=================================

Name: ascon_ctrl_fsm

Overview:
Control FSM that sequences the permutation_xor datapath through one Ascon-128 encryption: initialization (p12), associated-data blocks (p6), plaintext blocks (p6), then finalization (p12) with tag capture.
- Drives every datapath enable and the round-counter init strobes, and reads the datapath round counter back.
- Accepts data blocks from the top level through a valid/ack handshake.
- Reports busy/done.

Parameters:
NB_AD, 1, number of 64-bit associated-data blocks (must be ≥1)
NB_PT, 4, number of 64-bit plaintext blocks (must be ≥1)

Ports:
clock_i  in  1  clock, rising edge
resetb_i  in  1  synchronous reset, active-high (1 = reset)
start_i  in  1  start one encryption; sampled in IDLE only
round_i  in  4  round counter value from datapath (round_o)
data_valid_i  in  1  top level holds a valid AD/PT block
block_ack_o  out  1  block consumed this cycle (first round of a p6/p12 phase)
input_select_o  out  1  0 = load permutation_i, 1 = feed back state
ena_cpt_o  out  1  round counter increment
init_a_o  out  1  round counter load 0 (p12)
init_b_o  out  1  round counter load 6 (p6)
ena_xor_up_o  out  1  XOR data block into x0 at round input
ena_xor_down_o  out  1  XOR down-vector into x1..x4 at round input
down_sel_o  out  3  down-vector composition: bit0 key→x3x4, bit1 domain-sep 1→x4 LSB, bit2 key→x1x2; top XORs the selected pieces
ena_reg_state_o  out  1  state register enable
ena_cipher_o  out  1  capture ciphertext (x0 after xor_up)
ena_tag_o  out  1  capture tag
busy_o  out  1  state ≠ IDLE
done_o  out  1  one-cycle pulse, encryption complete

Behaviour:
- Reset: all outputs 0, state IDLE, AD/PT block counters 0. Reset mid-operation aborts immediately; no partial done.
- Round cycle: ena_reg_state_o=1 and ena_cpt_o=1. All other enables are 0 unless listed. Phase ends on the round cycle where round_i==11.
- IDLE: on start_i=1, assert init_a_o → INIT.
- INIT: 12 round cycles.
  - First cycle: input_select_o=0 (load IV‖K‖N); later cycles: 1.
  - Exit → AD_WAIT.
- AD_WAIT: init_b_o=1 every cycle. On data_valid_i=1 → AD.
- AD: 6 round cycles.
  - First cycle: block_ack_o=1, ena_xor_up_o=1; if AD block 0, also ena_xor_down_o=1 with down_sel bit0 (deferred init key XOR).
  - Exit: if ad_cnt==NB_AD-1 → PT_WAIT, else ad_cnt++ → AD_WAIT.
- PT_WAIT: on data_valid_i=1:
  - if pt_cnt==NB_PT-1 → assert init_a_o → FINAL;
  - else assert init_b_o → PT.
  - The init strobe is held every waiting cycle.
- PT: 6 round cycles.
  - First cycle: block_ack_o, ena_xor_up_o, ena_cipher_o; if PT block 0, also ena_xor_down_o with bit1.
  - Exit: pt_cnt++ → PT_WAIT.
- FINAL: 12 round cycles.
  - First cycle: block_ack_o, ena_xor_up_o, ena_cipher_o, ena_xor_down_o with bit2, plus bit1 if NB_PT==1.
  - Last cycle (round_i==11): ena_tag_o=1. Exit → DONE.
- DONE: done_o=1 for one cycle, counters cleared → IDLE.
- Handshake: data must stay stable from data_valid_i high until the ack cycle inclusive. data_valid_i is ignored outside WAIT states.
- start_i is ignored while busy_o=1.
- Latency (data_valid_i constantly 1, NB_AD=1, NB_PT=4): done_o asserts 54 cycles after the start_i cycle.
- If round_i never reaches 11 the FSM stalls. There is no timeout.

Optional Feature:
ASCON_CTRL_ABORT_EN:
- Defined: adds input abort_i (1 bit). abort_i=1 in any non-IDLE state → next cycle IDLE, counters cleared, no done_o; all enables are 0 from that cycle on. abort_i in IDLE has no effect. Reset has priority over abort.
- Undefined: the port and its logic are absent.

Decomposition:
- Add to ascon_pack: enum type_ctrl_state {IDLE, INIT, AD_WAIT, AD, PT_WAIT, PT, FINAL, DONE}; constants ROUND_P12_FIRST=0, ROUND_P6_FIRST=6, ROUND_LAST=11; DOWN_KEY_X34=0, DOWN_DSEP=1, DOWN_KEY_X12=2 bit indices.
- No sub-module: block counters and first-round flag are inline.

Test Plan:
1. Reset held 3 cycles mid-INIT → all outputs 0, busy_o=0, next start_i restarts from INIT with input_select_o=0.
2. Nominal run (NB_AD=1, NB_PT=4, valid always 1), with the real datapath connected and the project's existing test vectors → check output against those vectors:
   - done_o at cycle 54;
   - exactly 5 block_ack_o pulses;
   - 4 ena_cipher_o pulses;
   - 1 ena_tag_o pulse, on a round_i==11 cycle;
   - down_sel_o sequence 001, 010, 100.
3. data_valid_i held low 5 cycles in PT_WAIT → FSM holds with init_b_o=1 and no ena_reg_state_o; resumes with ack on the first round cycle; done_o delayed by exactly 5.
4. NB_PT=1 → FINAL first cycle down_sel_o=110; no PT state visited.
5. start_i pulsed during AD → ignored; a second start_i after done_o → a clean second run with identical output timing.
6. (ABORT_EN) abort_i in PT round 3 → IDLE next cycle, no done_o, no ena_tag_o; a subsequent run completes normally.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared types and constants for the Ascon-128 control path.
// Optional abort support is enabled with ASCON_CTRL_ABORT_EN.
package ascon_pack;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    AD_WAIT,
    AD,
    PT_WAIT,
    PT,
    FINAL,
    DONE
  } type_ctrl_state;

  localparam logic [3:0] ROUND_P12_FIRST = 4'd0;
  localparam logic [3:0] ROUND_P6_FIRST  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  localparam int DOWN_KEY_X34 = 0;
  localparam int DOWN_DSEP    = 1;
  localparam int DOWN_KEY_X12 = 2;

  typedef struct packed {
    logic       block_ack;
    logic       input_select;
    logic       ena_cpt;
    logic       init_a;
    logic       init_b;
    logic       ena_xor_up;
    logic       ena_xor_down;
    logic [2:0] down_sel;
    logic       ena_reg_state;
    logic       ena_cipher;
    logic       ena_tag;
    logic       busy;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/ascon_ctrl_fsm.sv
// Ascon-128 encryption sequencer driving the permutation_xor datapath.
// Define ASCON_CTRL_ABORT_EN to add the abort_i input.
module ascon_ctrl_fsm
  import ascon_pack::*;
#(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] round_i,
  input  logic       data_valid_i,
`ifdef ASCON_CTRL_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       block_ack_o,
  output logic       input_select_o,
  output logic       ena_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       ena_xor_up_o,
  output logic       ena_xor_down_o,
  output logic [2:0] down_sel_o,
  output logic       ena_reg_state_o,
  output logic       ena_cipher_o,
  output logic       ena_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [7:0] AD_LAST = 8'(NB_AD - 1);
  localparam logic [7:0] PT_LAST = 8'(NB_PT - 1);

  type_ctrl_state state_q, state_d;
  logic [7:0]     ad_cnt_q, ad_cnt_d;
  logic [7:0]     pt_cnt_q, pt_cnt_d;
  logic           first_q, first_d;
  logic           last_round;
  ctrl_t          c, co;

  assign last_round = (round_i == ROUND_LAST);

  always_comb begin
    c        = '0;
    state_d  = state_q;
    ad_cnt_d = ad_cnt_q;
    pt_cnt_d = pt_cnt_q;
    first_d  = first_q;
    c.busy   = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          c.init_a = 1'b1;
          first_d  = 1'b1;
          state_d  = INIT;
        end
      end
      INIT: begin
        c.ena_reg_state = 1'b1;
        c.ena_cpt       = 1'b1;
        c.input_select  = ~first_q;
        first_d         = 1'b0;
        if (last_round) state_d = AD_WAIT;
      end
      AD_WAIT: begin
        c.init_b = 1'b1;
        if (data_valid_i) begin
          first_d = 1'b1;
          state_d = AD;
        end
      end
      AD: begin
        c.ena_reg_state = 1'b1;
        c.ena_cpt       = 1'b1;
        c.input_select  = 1'b1;
        first_d         = 1'b0;
        if (first_q) begin
          c.block_ack  = 1'b1;
          c.ena_xor_up = 1'b1;
          // key XOR left over from initialization
          if (ad_cnt_q == 8'd0) begin
            c.ena_xor_down           = 1'b1;
            c.down_sel[DOWN_KEY_X34] = 1'b1;
          end
        end
        if (last_round) begin
          if (ad_cnt_q == AD_LAST) begin
            state_d = PT_WAIT;
          end else begin
            ad_cnt_d = ad_cnt_q + 8'd1;
            state_d  = AD_WAIT;
          end
        end
      end
      PT_WAIT: begin
        c.init_a = (pt_cnt_q == PT_LAST);
        c.init_b = (pt_cnt_q != PT_LAST);
        if (data_valid_i) begin
          first_d = 1'b1;
          state_d = (pt_cnt_q == PT_LAST) ? FINAL : PT;
        end
      end
      PT: begin
        c.ena_reg_state = 1'b1;
        c.ena_cpt       = 1'b1;
        c.input_select  = 1'b1;
        first_d         = 1'b0;
        if (first_q) begin
          c.block_ack  = 1'b1;
          c.ena_xor_up = 1'b1;
          c.ena_cipher = 1'b1;
          if (pt_cnt_q == 8'd0) begin
            c.ena_xor_down        = 1'b1;
            c.down_sel[DOWN_DSEP] = 1'b1;
          end
        end
        if (last_round) begin
          pt_cnt_d = pt_cnt_q + 8'd1;
          state_d  = PT_WAIT;
        end
      end
      FINAL: begin
        c.ena_reg_state = 1'b1;
        c.ena_cpt       = 1'b1;
        c.input_select  = 1'b1;
        first_d         = 1'b0;
        if (first_q) begin
          c.block_ack              = 1'b1;
          c.ena_xor_up             = 1'b1;
          c.ena_cipher             = 1'b1;
          c.ena_xor_down           = 1'b1;
          c.down_sel[DOWN_KEY_X12] = 1'b1;
          // a lone PT block also carries the domain separator
          c.down_sel[DOWN_DSEP]    = (NB_PT == 1);
        end
        if (last_round) begin
          c.ena_tag = 1'b1;
          state_d   = DONE;
        end
      end
      DONE: begin
        c.done   = 1'b1;
        ad_cnt_d = 8'd0;
        pt_cnt_d = 8'd0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ASCON_CTRL_ABORT_EN
    if (abort_i && state_q != IDLE) begin
      state_d  = IDLE;
      ad_cnt_d = 8'd0;
      pt_cnt_d = 8'd0;
      first_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock_i) begin
    if (resetb_i) begin
      state_q  <= IDLE;
      ad_cnt_q <= 8'd0;
      pt_cnt_q <= 8'd0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ad_cnt_q <= ad_cnt_d;
      pt_cnt_q <= pt_cnt_d;
      first_q  <= first_d;
    end
  end

  assign co = resetb_i ? '0 : c;

  assign block_ack_o     = co.block_ack;
  assign input_select_o  = co.input_select;
  assign ena_cpt_o       = co.ena_cpt;
  assign init_a_o        = co.init_a;
  assign init_b_o        = co.init_b;
  assign ena_xor_up_o    = co.ena_xor_up;
  assign ena_xor_down_o  = co.ena_xor_down;
  assign down_sel_o      = co.down_sel;
  assign ena_reg_state_o = co.ena_reg_state;
  assign ena_cipher_o    = co.ena_cipher;
  assign ena_tag_o       = co.ena_tag;
  assign busy_o          = co.busy;
  assign done_o          = co.done;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: expected per-cycle output schedule built
// from the phase rules, with a round counter standing in for the datapath.
module tb_ascon_ctrl_fsm;

  typedef struct packed {
    logic       ack;
    logic       sel;
    logic       cpt;
    logic       ia;
    logic       ib;
    logic       up;
    logic       dn;
    logic [2:0] ds;
    logic       rs;
    logic       cph;
    logic       tag;
    logic       busy;
    logic       done;
  } ov_t;

  typedef struct {
    logic       dut;
    logic       start;
    logic       valid;
    logic       rst;
    logic       abort;
    logic       run0;
    ov_t        exp;
    int         lat;
    int         acks;
    int         cphs;
    logic [8:0] dseq;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       st1, va1, ab1, st2, va2, ab2;
  logic [3:0] r1, r2;
  ov_t        o1, o2;

  logic ack1, sel1, cpt1, ia1, ib1, up1, dn1, rs1, cph1, tag1, busy1, done1;
  logic ack2, sel2, cpt2, ia2, ib2, up2, dn2, rs2, cph2, tag2, busy2, done2;
  logic [2:0] ds1, ds2;

  ascon_ctrl_fsm #(.NB_AD(1), .NB_PT(4)) dut1 (
    .clock_i(clk), .resetb_i(rst), .start_i(st1), .round_i(r1),
    .data_valid_i(va1),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(ab1),
`endif
    .block_ack_o(ack1), .input_select_o(sel1), .ena_cpt_o(cpt1),
    .init_a_o(ia1), .init_b_o(ib1), .ena_xor_up_o(up1),
    .ena_xor_down_o(dn1), .down_sel_o(ds1), .ena_reg_state_o(rs1),
    .ena_cipher_o(cph1), .ena_tag_o(tag1), .busy_o(busy1), .done_o(done1)
  );

  ascon_ctrl_fsm #(.NB_AD(2), .NB_PT(1)) dut2 (
    .clock_i(clk), .resetb_i(rst), .start_i(st2), .round_i(r2),
    .data_valid_i(va2),
`ifdef ASCON_CTRL_ABORT_EN
    .abort_i(ab2),
`endif
    .block_ack_o(ack2), .input_select_o(sel2), .ena_cpt_o(cpt2),
    .init_a_o(ia2), .init_b_o(ib2), .ena_xor_up_o(up2),
    .ena_xor_down_o(dn2), .down_sel_o(ds2), .ena_reg_state_o(rs2),
    .ena_cipher_o(cph2), .ena_tag_o(tag2), .busy_o(busy2), .done_o(done2)
  );

  assign o1 = {ack1, sel1, cpt1, ia1, ib1, up1, dn1, ds1,
               rs1, cph1, tag1, busy1, done1};
  assign o2 = {ack2, sel2, cpt2, ia2, ib2, up2, dn2, ds2,
               rs2, cph2, tag2, busy2, done2};

  // datapath round counter stand-ins
  always @(posedge clk) begin
    if (rst) r1 <= 4'd0;
    else if (ia1) r1 <= 4'd0;
    else if (ib1) r1 <= 4'd6;
    else if (cpt1) r1 <= r1 + 4'd1;
    if (rst) r2 <= 4'd0;
    else if (ia2) r2 <= 4'd0;
    else if (ib2) r2 <= 4'd6;
    else if (cpt2) r2 <= r2 + 4'd1;
  end

  ent_t sched[$];
  int   vec  = 0;
  int   miss = 0;

  task automatic add(input logic d, input logic s, input logic v,
                     input logic r, input ov_t e);
    ent_t t;
    t.dut = d; t.start = s; t.valid = v; t.rst = r; t.abort = 1'b0;
    t.run0 = 1'b0; t.exp = e; t.lat = 0; t.acks = 0; t.cphs = 0;
    t.dseq = '0;
    sched.push_back(t);
  endtask

  function automatic ov_t rnd();
    ov_t e = '0;
    e.busy = 1'b1; e.rs = 1'b1; e.cpt = 1'b1; e.sel = 1'b1;
    return e;
  endfunction

  task automatic gen_run(input logic d, input int na, input int np,
                         input int stall, input int stall_p,
                         input logic sad, input int lat, input int acks,
                         input int cphs, input logic [8:0] dseq);
    ov_t e;
    e = '0; e.ia = 1'b1;
    add(d, 1'b1, 1'b1, 1'b0, e);
    sched[sched.size()-1].run0 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = rnd(); e.sel = (i != 0);
      add(d, 1'b0, 1'b1, 1'b0, e);
    end
    for (int a = 0; a < na; a++) begin
      e = '0; e.busy = 1'b1; e.ib = 1'b1;
      add(d, 1'b0, 1'b1, 1'b0, e);
      for (int i = 0; i < 6; i++) begin
        e = rnd();
        if (i == 0) begin
          e.ack = 1'b1; e.up = 1'b1;
          if (a == 0) begin e.dn = 1'b1; e.ds = 3'b001; end
        end
        add(d, sad && a == 0 && i == 0, 1'b1, 1'b0, e);
      end
    end
    for (int p = 0; p < np; p++) begin
      e = '0; e.busy = 1'b1;
      if (p == np - 1) e.ia = 1'b1; else e.ib = 1'b1;
      if (p == stall_p)
        for (int k = 0; k < stall; k++) add(d, 1'b0, 1'b0, 1'b0, e);
      add(d, 1'b0, 1'b1, 1'b0, e);
      for (int i = 0; i < ((p == np - 1) ? 12 : 6); i++) begin
        e = rnd();
        if (i == 0) begin
          e.ack = 1'b1; e.up = 1'b1; e.cph = 1'b1;
          if (p == np - 1) begin
            e.dn = 1'b1; e.ds = (np == 1) ? 3'b110 : 3'b100;
          end else if (p == 0) begin
            e.dn = 1'b1; e.ds = 3'b010;
          end
        end
        if (p == np - 1 && i == 11) e.tag = 1'b1;
        add(d, 1'b0, 1'b1, 1'b0, e);
      end
    end
    e = '0; e.busy = 1'b1; e.done = 1'b1;
    add(d, 1'b0, 1'b1, 1'b0, e);
    sched[sched.size()-1].lat  = lat;
    sched[sched.size()-1].acks = acks;
    sched[sched.size()-1].cphs = cphs;
    sched[sched.size()-1].dseq = dseq;
    add(d, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk(input bit ok, input string nm, input int got,
                     input int want);
    vec++;
    if (!ok) begin
      miss++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int   mark, cyc, done_at, n_ack, n_cph, n_tag;
    logic [8:0] seq;
    ent_t e;
    ov_t  act;
    logic [3:0] rv;

    rst = 1'b1; st1 = 0; va1 = 0; ab1 = 0; st2 = 0; va2 = 0; ab2 = 0;
    add(1'b0, 1'b0, 1'b0, 1'b1, '0);
    add(1'b0, 1'b0, 1'b0, 1'b1, '0);
    add(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // reset during INIT round 5, then clean restart
    mark = sched.size();
    gen_run(1'b0, 1, 4, 0, -1, 1'b0, 54, 5, 4, 9'b001_010_100);
    sched = sched[0:mark+5];
    for (int k = 0; k < 3; k++) add(1'b0, 1'b0, 1'b0, 1'b1, '0);
    add(1'b0, 1'b0, 1'b0, 1'b0, '0);

    gen_run(1'b0, 1, 4, 0, -1, 1'b0, 54, 5, 4, 9'b001_010_100);
    gen_run(1'b0, 1, 4, 5, 1, 1'b0, 59, 5, 4, 9'b001_010_100);
    gen_run(1'b0, 1, 4, 0, -1, 1'b1, 54, 5, 4, 9'b001_010_100);
    gen_run(1'b0, 1, 4, 0, -1, 1'b0, 54, 5, 4, 9'b001_010_100);
    gen_run(1'b1, 2, 1, 0, -1, 1'b0, 40, 3, 1, 9'b000_001_110);
`ifdef ASCON_CTRL_ABORT_EN
    mark = sched.size();
    gen_run(1'b0, 1, 4, 0, -1, 1'b0, 54, 5, 4, 9'b001_010_100);
    sched = sched[0:mark+23];
    sched[mark+23].abort = 1'b1;
    add(1'b0, 1'b0, 1'b1, 1'b0, '0);
    add(1'b0, 1'b0, 1'b1, 1'b0, '0);
    gen_run(1'b0, 1, 4, 0, -1, 1'b0, 54, 5, 4, 9'b001_010_100);
`endif

    cyc = 0; done_at = -1; n_ack = 0; n_cph = 0; n_tag = 0; seq = '0;
    for (int i = 0; i < sched.size(); i++) begin
      e = sched[i];
      @(negedge clk);
      rst = e.rst;
      st1 = ~e.dut & e.start; va1 = ~e.dut & e.valid; ab1 = ~e.dut & e.abort;
      st2 = e.dut & e.start;  va2 = e.dut & e.valid;  ab2 = e.dut & e.abort;
      #1;
      act = e.dut ? o2 : o1;
      rv  = e.dut ? r2 : r1;
      vec++;
      if (act !== e.exp) begin
        miss++;
        $display("FAIL step %0d outputs: got %b want %b", i, act, e.exp);
      end
      if (e.run0) begin
        cyc = 0; done_at = -1; n_ack = 0; n_cph = 0; n_tag = 0; seq = '0;
      end else begin
        cyc++;
      end
      n_ack += int'(act.ack);
      n_cph += int'(act.cph);
      n_tag += int'(act.tag);
      if (act.done) done_at = cyc;
      if (act.ds != 3'b000) seq = {seq[5:0], act.ds};
      if (act.tag) chk(rv == 4'd11, "tag_round", int'(rv), 11);
      if (e.lat != 0) begin
        chk(done_at == e.lat, "done_latency", done_at, e.lat);
        chk(n_ack == e.acks, "ack_pulses", n_ack, e.acks);
        chk(n_cph == e.cphs, "cipher_pulses", n_cph, e.cphs);
        chk(n_tag == 1, "tag_pulses", n_tag, 1);
        chk(seq == e.dseq, "down_sel_seq", int'(seq), int'(e.dseq));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
